vga_sync_rx: RTL and testbench
==============================

Name: vga_sync_rx

Overview:
- Receive side of the VGA timing interface; the counterpart of the vga timing generator.
- Samples HS/VS/RGB in the pixel-clock domain and recovers the pixel coordinates x/y and a data-enable.
- Checks the incoming timing against the configured mode and reports lock.
- Used as a loopback checker and as the front end of a capture path that writes pixels into a framebuffer.

Parameters:
- HSYNC_BITS, 11, width of the horizontal counter and x_o.
- VSYNC_BITS, 11, width of the vertical counter and y_o.
- HD, 1280, active pixels per line.
- VD, 1024, active lines per frame.
- HFP, 48, horizontal front porch in clocks.
- HSW, 112, HS pulse width in clocks.
- HBP, 248, horizontal back porch in clocks.
- VFP, 1, vertical front porch in lines.
- VSW, 3, VS pulse width in lines.
- VBP, 38, vertical back porch in lines.
- LOCK_FRAMES, 2, consecutive good frames required to lock (1..15).
- Derived values: H_TOTAL=HD+HFP+HSW+HBP, V_TOTAL=VD+VFP+VSW+VBP. Both must fit their counter widths.

Ports:
- clk_i  in  1  pixel clock.
- arstn_i  in  1  asynchronous active-low reset.
- VGA_HS_i  in  1  horizontal sync, active high, synchronous to clk_i.
- VGA_VS_i  in  1  vertical sync, active high, synchronous to clk_i.
- RGB_i  in  12  pixel data.
- x_o  out  HSYNC_BITS  active x coordinate, valid when de_o=1.
- y_o  out  VSYNC_BITS  active y coordinate, valid when de_o=1.
- de_o  out  1  active pixel AND locked.
- pixel_o  out  12  RGB aligned with x_o/y_o.
- frame_start_o  out  1  one-cycle pulse at vertical counter reset.
- locked_o  out  1  timing locked.
- err_o  out  1  one-cycle pulse on any timing violation.
- frame_crc_o  out  16  see Optional Feature.
- crc_valid_o  out  1  see Optional Feature.

Behaviour:
- Reset: every register is cleared asynchronously when arstn_i=0. All outputs are 0 and the FSM is UNLOCKED.
- Stage 1 registers HS, VS and RGB. Stage 2 registers the outputs. Latency from input pins to outputs is 2 clocks, fixed.
- HS leading edge = hs_q=1 && hs_qq=0, detected in stage 1.
  - On that edge h_cnt is loaded with 0; otherwise h_cnt increments.
  - h_cnt saturates at 2^HSYNC_BITS-1. Saturation gives one err pulse and does not repeat until the next HS edge.
- Line period check: at each HS edge the period is prev h_cnt+1. The line is bad if the period is not H_TOTAL. The first edge after reset or after UNLOCKED is exempt.
- VS leading edge sets vs_pend.
  - At the next HS edge, or the same-cycle HS edge, v_cnt is loaded with 0, vs_pend clears and frame_start fires.
  - Otherwise each HS edge increments v_cnt, saturating.
- Frame check: at frame start the frame is bad if prev v_cnt+1 is not V_TOTAL or any line in it was bad.
- Active region: h_cnt in [HSW+HBP, HSW+HBP+HD-1] and v_cnt in [VSW+VBP, VSW+VBP+VD-1].
  - x = h_cnt-(HSW+HBP), y = v_cnt-(VSW+VBP).
  - Outside the region x_o/y_o hold 0 and pixel_o is 0.
- FSM:
  - UNLOCKED: on the first frame start go to ACQUIRE and set good=0.
  - ACQUIRE: at each frame start, a good frame increments good and a bad frame clears good.
  - ACQUIRE: when good reaches LOCK_FRAMES, go to LOCKED; locked_o rises with that frame_start pulse.
  - LOCKED: a bad line, a bad frame or a saturation goes to UNLOCKED in the same cycle as the err_o pulse. locked_o and de_o drop on that cycle.
- err_o is reported in every state, except for the exempt first edges.
- Simultaneous VS and HS edges are a normal frame start, not an error.
- Reset asserted mid-frame aborts immediately. After release the block starts from UNLOCKED.

Optional Feature:
- Macro: VGA_SYNC_RX_CRC_EN.
- Enabled:
  - Computes CRC-16-CCITT (poly 0x1021, init 0xFFFF, MSB first) over pixel_o for every de_o cycle, 12 bits per pixel with the upper 4 data bits zero-extended to 16.
  - At frame_start the running CRC is copied to frame_crc_o and crc_valid_o pulses for 1 cycle, but only if the completed frame was fully locked. The running CRC then reinitialises.
- Disabled: frame_crc_o=0 and crc_valid_o=0 at all times, with no CRC logic.

Test Plan:
- Bench parameters: HD=8, VD=4, HFP=2, HSW=2, HBP=2, VFP=1, VSW=1, VBP=1, giving H_TOTAL=14 and V_TOTAL=7.
- Drive ideal timing and apply reset release -> first frame_start, then locked_o rises at the 3rd frame_start (LOCK_FRAMES=2). err_o is never asserted.
- Locked, RGB=x+16*y -> de_o high for 8 clocks per line on 4 lines. x_o=0..7, pixel_o equals the input 2 clocks earlier, and y_o=0..3.
- Locked, one line shortened to 13 clocks -> one err_o pulse at that HS edge; locked_o and de_o drop the same cycle; relock after 2 further good frames.
- HS held low for 2048 clocks -> a single err_o pulse at saturation and locked_o=0.
- arstn_i pulsed low mid-line while locked -> all outputs 0 the same cycle; the lock sequence then repeats as in the first scenario.
- Macro on, constant RGB=0x000 -> crc_valid_o pulses each frame_start after lock, with frame_crc_o equal to the reference model CRC of 32 zero pixels. Macro off -> frame_crc_o and crc_valid_o stay 0.

Source files
------------

// File: rtl/vga_sync_rx.sv
// VGA timing receiver: recovers x/y/de from HS/VS, checks timing against the mode, reports lock.
// Optional per-frame CRC-16-CCITT over locked active pixels when VGA_SYNC_RX_CRC_EN is defined.
module vga_sync_rx #(
  parameter int unsigned HSYNC_BITS  = 11,
  parameter int unsigned VSYNC_BITS  = 11,
  parameter int unsigned HD          = 1280,
  parameter int unsigned VD          = 1024,
  parameter int unsigned HFP         = 48,
  parameter int unsigned HSW         = 112,
  parameter int unsigned HBP         = 248,
  parameter int unsigned VFP         = 1,
  parameter int unsigned VSW         = 3,
  parameter int unsigned VBP         = 38,
  parameter int unsigned LOCK_FRAMES = 2
) (
  input  logic                  clk_i,
  input  logic                  arstn_i,
  input  logic                  VGA_HS_i,
  input  logic                  VGA_VS_i,
  input  logic [11:0]           RGB_i,
  output logic [HSYNC_BITS-1:0] x_o,
  output logic [VSYNC_BITS-1:0] y_o,
  output logic                  de_o,
  output logic [11:0]           pixel_o,
  output logic                  frame_start_o,
  output logic                  locked_o,
  output logic                  err_o,
  output logic [15:0]           frame_crc_o,
  output logic                  crc_valid_o
);

  localparam int unsigned H_TOTAL = HD + HFP + HSW + HBP;
  localparam int unsigned V_TOTAL = VD + VFP + VSW + VBP;

  localparam logic [HSYNC_BITS-1:0] H_ONE    = HSYNC_BITS'(1);
  localparam logic [HSYNC_BITS-1:0] H_MAX    = {HSYNC_BITS{1'b1}};
  localparam logic [HSYNC_BITS-1:0] H_LAST   = HSYNC_BITS'(H_TOTAL - 1);
  localparam logic [HSYNC_BITS-1:0] H_ACT_LO = HSYNC_BITS'(HSW + HBP);
  localparam logic [HSYNC_BITS-1:0] H_ACT_HI = HSYNC_BITS'(HSW + HBP + HD - 1);

  localparam logic [VSYNC_BITS-1:0] V_ONE    = VSYNC_BITS'(1);
  localparam logic [VSYNC_BITS-1:0] V_MAX    = {VSYNC_BITS{1'b1}};
  localparam logic [VSYNC_BITS-1:0] V_LAST   = VSYNC_BITS'(V_TOTAL - 1);
  localparam logic [VSYNC_BITS-1:0] V_ACT_LO = VSYNC_BITS'(VSW + VBP);
  localparam logic [VSYNC_BITS-1:0] V_ACT_HI = VSYNC_BITS'(VSW + VBP + VD - 1);

  localparam logic [3:0] GOOD_ONE    = 4'd1;
  localparam logic [3:0] GOOD_TARGET = 4'(LOCK_FRAMES);

  typedef enum logic [1:0] {
    StUnlocked,
    StAcquire,
    StLocked
  } state_e;

  // Stage 1: input capture
  logic        r_hs_q, r_hs_qq, r_vs_q, r_vs_qq;
  logic [11:0] r_rgb_q;

  // Timing tracking state
  logic [HSYNC_BITS-1:0] r_h_cnt;
  logic [VSYNC_BITS-1:0] r_v_cnt;
  logic                  r_vs_pend;
  logic                  r_h_armed;
  logic                  r_v_armed;
  logic                  r_frame_bad;
  state_e                r_state;
  logic [3:0]            r_good;

  // Stage 2: output registers
  logic [HSYNC_BITS-1:0] r_x;
  logic [VSYNC_BITS-1:0] r_y;
  logic [11:0]           r_pixel;
  logic                  r_de, r_fs, r_err;

  logic                  w_hs_edge, w_vs_edge;
  logic                  w_h_sat, w_line_bad, w_fs;
  logic                  w_frame_len_bad, w_frame_bad, w_err;
  logic                  w_active, w_to_unlock, w_vs_pend_nxt;
  logic [HSYNC_BITS-1:0] w_h_cur;
  logic [VSYNC_BITS-1:0] w_v_cur;
  state_e                w_state_nxt;
  logic [3:0]            w_good_nxt;

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      r_hs_q  <= 1'b0;
      r_hs_qq <= 1'b0;
      r_vs_q  <= 1'b0;
      r_vs_qq <= 1'b0;
      r_rgb_q <= '0;
    end else begin
      r_hs_q  <= VGA_HS_i;
      r_hs_qq <= r_hs_q;
      r_vs_q  <= VGA_VS_i;
      r_vs_qq <= r_vs_q;
      r_rgb_q <= RGB_i;
    end
  end

  assign w_hs_edge = r_hs_q & ~r_hs_qq;
  assign w_vs_edge = r_vs_q & ~r_vs_qq;

  // w_h_cur/w_v_cur are the coordinates of the pixel now sitting in stage 1.
  always_comb begin
    w_h_cur = r_h_cnt;
    if (w_hs_edge) begin
      w_h_cur = '0;
    end else if (r_h_cnt != H_MAX) begin
      w_h_cur = r_h_cnt + H_ONE;
    end
  end

  assign w_h_sat    = ~w_hs_edge & (r_h_cnt == (H_MAX - H_ONE));
  assign w_line_bad = w_hs_edge & r_h_armed & (r_h_cnt != H_LAST);
  assign w_fs       = w_hs_edge & (r_vs_pend | w_vs_edge);

  always_comb begin
    w_v_cur       = r_v_cnt;
    w_vs_pend_nxt = r_vs_pend;
    if (w_fs) begin
      w_v_cur       = '0;
      w_vs_pend_nxt = 1'b0;
    end else begin
      if (w_hs_edge && (r_v_cnt != V_MAX)) begin
        w_v_cur = r_v_cnt + V_ONE;
      end
      if (w_vs_edge) begin
        w_vs_pend_nxt = 1'b1;
      end
    end
  end

  assign w_frame_len_bad = w_fs & r_v_armed & (r_v_cnt != V_LAST);
  assign w_frame_bad     = w_frame_len_bad | (w_fs & r_v_armed & (r_frame_bad | w_line_bad));
  assign w_err           = w_line_bad | w_h_sat | w_frame_len_bad;

  assign w_active = (w_h_cur >= H_ACT_LO) && (w_h_cur <= H_ACT_HI) &&
                    (w_v_cur >= V_ACT_LO) && (w_v_cur <= V_ACT_HI);

  always_comb begin
    w_state_nxt = r_state;
    w_good_nxt  = r_good;
    unique case (r_state)
      StUnlocked: begin
        if (w_fs) begin
          w_state_nxt = StAcquire;
          w_good_nxt  = '0;
        end
      end
      StAcquire: begin
        if (w_fs) begin
          w_good_nxt = w_frame_bad ? 4'd0 : (r_good + GOOD_ONE);
          if (!w_frame_bad && ((r_good + GOOD_ONE) == GOOD_TARGET)) begin
            w_state_nxt = StLocked;
          end
        end
      end
      StLocked: begin
        if (w_err || w_frame_bad) begin
          w_state_nxt = StUnlocked;
        end
      end
      default: w_state_nxt = StUnlocked;
    endcase
  end

  assign w_to_unlock = (r_state == StLocked) && (w_state_nxt == StUnlocked);

  // Losing lock re-arms the exemption so the first edge/frame afterwards is not judged.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      r_h_cnt     <= '0;
      r_v_cnt     <= '0;
      r_vs_pend   <= 1'b0;
      r_h_armed   <= 1'b0;
      r_v_armed   <= 1'b0;
      r_frame_bad <= 1'b0;
      r_state     <= StUnlocked;
      r_good      <= '0;
    end else begin
      r_h_cnt   <= w_h_cur;
      r_v_cnt   <= w_v_cur;
      r_vs_pend <= w_vs_pend_nxt;
      r_state   <= w_state_nxt;
      r_good    <= w_good_nxt;
      if (w_to_unlock) begin
        r_h_armed <= 1'b0;
      end else if (w_hs_edge) begin
        r_h_armed <= 1'b1;
      end
      if (w_to_unlock) begin
        r_v_armed <= 1'b0;
      end else if (w_fs) begin
        r_v_armed <= 1'b1;
      end
      if (w_fs || w_to_unlock) begin
        r_frame_bad <= 1'b0;
      end else if (w_line_bad || w_h_sat) begin
        r_frame_bad <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      r_x     <= '0;
      r_y     <= '0;
      r_pixel <= '0;
      r_de    <= 1'b0;
      r_fs    <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_x     <= w_active ? (w_h_cur - H_ACT_LO) : '0;
      r_y     <= w_active ? (w_v_cur - V_ACT_LO) : '0;
      r_pixel <= w_active ? r_rgb_q : 12'h000;
      r_de    <= w_active && (w_state_nxt == StLocked);
      r_fs    <= w_fs;
      r_err   <= w_err;
    end
  end

  assign x_o           = r_x;
  assign y_o           = r_y;
  assign pixel_o       = r_pixel;
  assign de_o          = r_de;
  assign frame_start_o = r_fs;
  assign err_o         = r_err;
  assign locked_o      = (r_state == StLocked);

`ifdef VGA_SYNC_RX_CRC_EN
  function automatic logic [15:0] crc16_px(input logic [15:0] crc, input logic [11:0] px);
    logic [15:0] c;
    logic [15:0] d;
    logic        fb;
    c = crc;
    d = {4'h0, px};
    for (int i = 15; i >= 0; i--) begin
      fb = c[15] ^ d[i];
      c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    end
    return c;
  endfunction

  logic [15:0] r_crc, r_frame_crc;
  logic        r_crc_valid, r_full;
  logic [15:0] w_crc_cur;

  // Fold in the pixel currently on the outputs so a frame ending on a de cycle is complete.
  assign w_crc_cur = r_de ? crc16_px(r_crc, r_pixel) : r_crc;

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      r_crc       <= '0;
      r_frame_crc <= '0;
      r_crc_valid <= 1'b0;
      r_full      <= 1'b0;
    end else begin
      r_crc_valid <= 1'b0;
      if (w_fs) begin
        r_crc  <= 16'hFFFF;
        r_full <= (w_state_nxt == StLocked);
        if (r_full && (w_state_nxt == StLocked)) begin
          r_frame_crc <= w_crc_cur;
          r_crc_valid <= 1'b1;
        end
      end else begin
        r_crc <= w_crc_cur;
        if (w_state_nxt != StLocked) begin
          r_full <= 1'b0;
        end
      end
    end
  end

  assign frame_crc_o = r_frame_crc;
  assign crc_valid_o = r_crc_valid;
`else
  assign frame_crc_o = 16'h0000;
  assign crc_valid_o = 1'b0;
`endif

endmodule

// File: tb/tb_vga_sync_rx.sv
// Randomized bench for vga_sync_rx: a frame generator annotates each pixel with the outputs
// expected two clocks later, derived from frame position and a frame-start count for lock.
module tb_vga_sync_rx;

  localparam int unsigned HB = 11, VB = 11;
  localparam int unsigned HD = 8, VD = 4, HFP = 2, HSW = 2, HBP = 2, VFP = 1, VSW = 1, VBP = 1;
  localparam int unsigned LOCKF = 2;
  localparam int H_TOT = HD + HFP + HSW + HBP;
  localparam int V_TOT = VD + VFP + VSW + VBP;
  localparam int H_LO = HSW + HBP;
  localparam int V_LO = VSW + VBP;

  logic          clk, arstn, hs, vs;
  logic [11:0]   rgb;
  logic [HB-1:0] x;
  logic [VB-1:0] y;
  logic          de, fs, lck, err, cv;
  logic [11:0]   pix;
  logic [15:0]   crc;

  vga_sync_rx #(
    .HSYNC_BITS(HB), .VSYNC_BITS(VB), .HD(HD), .VD(VD), .HFP(HFP), .HSW(HSW), .HBP(HBP),
    .VFP(VFP), .VSW(VSW), .VBP(VBP), .LOCK_FRAMES(LOCKF)
  ) u_dut (
    .clk_i(clk), .arstn_i(arstn), .VGA_HS_i(hs), .VGA_VS_i(vs), .RGB_i(rgb),
    .x_o(x), .y_o(y), .de_o(de), .pixel_o(pix), .frame_start_o(fs), .locked_o(lck),
    .err_o(err), .frame_crc_o(crc), .crc_valid_o(cv)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [HB-1:0] x;
    logic [VB-1:0] y;
    logic          de;
    logic [11:0]   pix;
    logic          fs;
    logic          err;
    logic          lck;
    logic          cv;
    logic [15:0]   crc;
  } exp_t;

  exp_t        q[$];
  logic [11:0] m_pix[$];
  int          n_vec = 0;
  int          n_bad = 0;
  int          m_fs_cnt = 0;
  bit          m_full = 0;
  bit          short_pend = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // CRC-16-CCITT of the pixels collected for the frame, each as a 16-bit word MSB first.
  function automatic logic [15:0] ref_crc();
    logic [15:0] c;
    logic [15:0] w;
    c = 16'hFFFF;
    foreach (m_pix[i]) begin
      w = {4'h0, m_pix[i]};
      for (int b = 15; b >= 0; b--) begin
        if (c[15] ^ w[b]) c = (c << 1) ^ 16'h1021;
        else              c = c << 1;
      end
    end
    return c;
  endfunction

  task automatic check_zero(input string tag);
    check_val({tag, "_x"}, 32'(x), 32'd0);
    check_val({tag, "_y"}, 32'(y), 32'd0);
    check_val({tag, "_de"}, 32'(de), 32'd0);
    check_val({tag, "_pixel"}, 32'(pix), 32'd0);
    check_val({tag, "_fs"}, 32'(fs), 32'd0);
    check_val({tag, "_locked"}, 32'(lck), 32'd0);
    check_val({tag, "_err"}, 32'(err), 32'd0);
    check_val({tag, "_crc_valid"}, 32'(cv), 32'd0);
    check_val({tag, "_frame_crc"}, 32'(crc), 32'd0);
  endtask

  task automatic compare_head();
    exp_t e;
    if (q.size() < 2) return;
    e = q.pop_front();
    check_val("de", 32'(de), 32'(e.de));
    check_val("x", 32'(x), 32'(e.x));
    check_val("y", 32'(y), 32'(e.y));
    check_val("pixel", 32'(pix), 32'(e.pix));
    check_val("frame_start", 32'(fs), 32'(e.fs));
    check_val("err", 32'(err), 32'(e.err));
    check_val("locked", 32'(lck), 32'(e.lck));
`ifdef VGA_SYNC_RX_CRC_EN
    check_val("crc_valid", 32'(cv), 32'(e.cv));
    if (e.cv) check_val("frame_crc", 32'(crc), 32'(e.crc));
`else
    check_val("crc_valid_off", 32'(cv), 32'd0);
    check_val("frame_crc_off", 32'(crc), 32'd0);
`endif
  endtask

  // Apply one pixel clock of input and queue what must appear two clocks later.
  task automatic emit(input bit h_s, input bit v_s, input int h, input int l, input bit is_fs,
                      input bit is_err, input logic [11:0] px);
    exp_t e;
    bit   act;
    act   = (h >= H_LO) && (h < H_LO + HD) && (l >= V_LO) && (l < V_LO + VD);
    e.cv  = 1'b0;
    e.crc = 16'h0000;
    if (is_err) begin
      m_fs_cnt = 0;
      m_full   = 0;
    end
    if (is_fs) begin
      if (m_fs_cnt < 100) m_fs_cnt++;
      e.lck  = (m_fs_cnt > LOCKF);
      e.cv   = m_full && e.lck;
      e.crc  = ref_crc();
      m_pix.delete();
      m_full = e.lck;
    end else begin
      e.lck = (m_fs_cnt > LOCKF);
    end
    e.de  = act && e.lck;
    if (e.de) m_pix.push_back(px);
    e.x   = act ? HB'(h - H_LO) : '0;
    e.y   = act ? VB'(l - V_LO) : '0;
    e.pix = act ? px : 12'h000;
    e.fs  = is_fs;
    e.err = is_err;
    @(negedge clk);
    compare_head();
    hs  = h_s;
    vs  = v_s;
    rgb = px;
    q.push_back(e);
  endtask

  function automatic logic [11:0] pick_rgb(input int mode, input int h, input int l);
    if (mode == 1) return 12'h000;
    if (mode == 2 && h >= H_LO && h < H_LO + HD && l >= V_LO && l < V_LO + VD)
      return 12'((h - H_LO) + 16 * (l - V_LO));
    return 12'($urandom);
  endfunction

  // One frame of ideal timing; short_line drops its last clock, abort_line stops mid-line.
  task automatic gen_frame(input int mode, input int short_line, input int abort_line);
    int len;
    for (int l = 0; l < V_TOT; l++) begin
      len = (l == short_line) ? H_TOT - 1 : H_TOT;
      for (int h = 0; h < len; h++) begin
        if (l == abort_line && h == 6) return;
        emit(h < HSW, l < VSW, h, l, (l == 0 && h == 0), (h == 0 && short_pend),
             pick_rgb(mode, h, l));
        if (h == 0) short_pend = 0;
      end
      if (l == short_line) short_pend = 1;
    end
  endtask

  // HS pulse then 2048 clocks low: the counter saturates at 2047 exactly once.
  task automatic gen_sat();
    for (int h = 0; h < HSW + 2048; h++) begin
      emit(h < HSW, 1'b0, h, V_TOT, 1'b0, (h == 2047), 12'($urandom));
    end
  endtask

  task automatic reset_model();
    q.delete();
    m_pix.delete();
    m_fs_cnt   = 0;
    m_full     = 0;
    short_pend = 0;
  endtask

  task automatic async_reset_pulse();
    #2;
    arstn = 1'b0;
    #1;
    check_zero("async_rst");
    hs  = 1'b0;
    vs  = 1'b0;
    rgb = 12'h000;
    repeat (2) @(negedge clk);
    reset_model();
    arstn = 1'b1;
  endtask

  initial begin
    #2_000_000;
    n_bad++;
    $display("FAIL watchdog: got timeout, want finish at %0t", $time);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    arstn = 1'b0;
    hs    = 1'b0;
    vs    = 1'b0;
    rgb   = 12'h000;
    repeat (3) @(negedge clk);
    check_zero("reset");
    reset_model();
    arstn = 1'b1;

    repeat (4) gen_frame(2, -1, -1);    // lock at 3rd frame start, x+16*y pattern
    repeat (2) gen_frame(0, -1, -1);
    gen_frame(0, 3, -1);                // 13-clock line while locked
    repeat (4) gen_frame(0, -1, -1);    // relock
    gen_sat();
    repeat (5) gen_frame(1, -1, -1);    // zero RGB frames after relock
    gen_frame(0, -1, 3);
    async_reset_pulse();
    repeat (4) gen_frame(0, -1, -1);
    gen_frame(0, -1, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
